seq_decoder: RTL and testbench



---
 rtl/seq_decoder.sv | 278 +++++++++++++++++++++++++++
 tb/tb_seq_decoder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_decoder.sv
// seq_decoder: multi-cycle fetch/execute control unit.
// Owns the PC, sequences ROM fetch, GPR/ALU/stack strobes and RAM handshakes.
package seq_decoder_pkg;
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LD  = 8'h01;
    localparam logic [7:0] OP_LDR = 8'h02;
    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_SUB = 8'h04;
    localparam logic [7:0] OP_INC = 8'h05;
    localparam logic [7:0] OP_DEC = 8'h06;
    localparam logic [7:0] OP_CLR = 8'h07;
    localparam logic [7:0] OP_FIL = 8'h08;
    localparam logic [7:0] OP_PSH = 8'h09;
    localparam logic [7:0] OP_POP = 8'h0A;
    localparam logic [7:0] OP_JMP = 8'h0B;
    localparam logic [7:0] OP_JZ  = 8'h0C;
    localparam logic [7:0] OP_LDM = 8'h0D;
    localparam logic [7:0] OP_STM = 8'h0E;
    localparam logic [7:0] OP_HLT = 8'h0F;

    localparam logic [4:0] ALU_NONE = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;

    localparam logic [1:0] FLT_NONE = 2'd0;
    localparam logic [1:0] FLT_OVF  = 2'd1;
    localparam logic [1:0] FLT_UNF  = 2'd2;
    localparam logic [1:0] FLT_MEM  = 2'd3;
endpackage

module seq_decoder
    import seq_decoder_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int REG_AW      = 3,
    parameter int PC_W        = 8,
    parameter int MEM_AW      = 8,
    parameter int MEM_TIMEOUT = 15,
    parameter int INSTR_W     = 8 + 2 * DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               gpr_w_enable,
    output logic [REG_AW-1:0]  gpr_w_addr,
    output logic [DATA_W-1:0]  gpr_w_data,
    output logic [REG_AW-1:0]  gpr_r_addr_a,
    output logic [REG_AW-1:0]  gpr_r_addr_b,
    input  logic [DATA_W-1:0]  gpr_r_data_a,
    input  logic [DATA_W-1:0]  gpr_r_data_b,
    output logic               flags_w_enable,
    input  logic               flag_z,
    output logic [4:0]         alu_operation,
    output logic [DATA_W-1:0]  alu_A,
    output logic [DATA_W-1:0]  alu_B,
    input  logic [DATA_W-1:0]  alu_C,
    output logic               stack_push_enable,
    output logic [DATA_W-1:0]  stack_push_data,
    output logic               stack_pop_enable,
    input  logic [DATA_W-1:0]  stack_pop_data,
    input  logic               stack_full,
    input  logic               stack_empty,
    output logic               mem_req,
    output logic               mem_we,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               halted,
    output logic [1:0]         fault
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM_WAIT,
        S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         fault_q, fault_d;

    logic [INSTR_W-1:0] instr;
    logic [7:0]         opcode;
    logic [DATA_W-1:0]  arg_a;
    logic [DATA_W-1:0]  arg_b;
    logic [REG_AW-1:0]  ra;
    logic [REG_AW-1:0]  rb;
    logic [PC_W-1:0]    pc_inc;
    logic               is_stm;
    logic               unused_bits;

    // EXEC decodes the ROM word directly; MEM_WAIT replays it from IR
    assign instr  = (state_q == S_EXEC) ? rom_data : ir_q;
    assign opcode = instr[INSTR_W-1 -: 8];
    assign arg_a  = instr[2*DATA_W-1 -: DATA_W];
    assign arg_b  = instr[DATA_W-1:0];
    assign ra     = arg_a[REG_AW-1:0];
    assign rb     = arg_b[REG_AW-1:0];
    assign pc_inc = pc_q + PC_W'(1);
    assign is_stm = (opcode == OP_STM);

    assign unused_bits = ^arg_a[DATA_W-1:REG_AW];

    assign rom_addr = pc_q;
    assign halted   = (state_q == S_HALT);
    assign fault    = fault_q;

    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        ir_d              = ir_q;
        cnt_d             = cnt_q;
        fault_d           = fault_q;
        gpr_w_enable      = 1'b0;
        gpr_w_addr        = '0;
        gpr_w_data        = '0;
        gpr_r_addr_a      = '0;
        gpr_r_addr_b      = '0;
        flags_w_enable    = 1'b0;
        alu_operation     = ALU_NONE;
        alu_A             = '0;
        alu_B             = '0;
        stack_push_enable = 1'b0;
        stack_push_data   = '0;
        stack_pop_enable  = 1'b0;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;

        unique case (state_q)
            S_FETCH: begin
                state_d = S_EXEC;
            end

            S_EXEC: begin
                ir_d    = rom_data;
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (opcode)
                    OP_LD: begin
                        gpr_r_addr_b = rb;
                        gpr_w_enable = 1'b1;
                        gpr_w_addr   = ra;
                        gpr_w_data   = gpr_r_data_b;
                    end
                    OP_LDR: begin
                        gpr_w_enable = 1'b1;
                        gpr_w_addr   = ra;
                        gpr_w_data   = arg_b;
                    end
                    OP_ADD, OP_SUB: begin
                        gpr_r_addr_a   = ra;
                        gpr_r_addr_b   = rb;
                        alu_A          = gpr_r_data_a;
                        alu_B          = gpr_r_data_b;
                        alu_operation  = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
                        flags_w_enable = 1'b1;
                        gpr_w_enable   = 1'b1;
                        gpr_w_addr     = ra;
                        gpr_w_data     = alu_C;
                    end
                    OP_INC, OP_DEC: begin
                        gpr_r_addr_a   = ra;
                        alu_A          = gpr_r_data_a;
                        alu_B          = DATA_W'(1);
                        alu_operation  = (opcode == OP_INC) ? ALU_ADD : ALU_SUB;
                        flags_w_enable = 1'b1;
                        gpr_w_enable   = 1'b1;
                        gpr_w_addr     = ra;
                        gpr_w_data     = alu_C;
                    end
                    OP_CLR, OP_FIL: begin
                        gpr_w_enable = 1'b1;
                        gpr_w_addr   = ra;
                        gpr_w_data   = (opcode == OP_FIL) ? '1 : '0;
                    end
                    OP_PSH: begin
                        gpr_r_addr_a = ra;
                        if (stack_full) begin
                            fault_d = FLT_OVF;
                            state_d = S_HALT;
                            pc_d    = pc_q;
                        end else begin
                            stack_push_enable = 1'b1;
                            stack_push_data   = gpr_r_data_a;
                        end
                    end
                    OP_POP: begin
                        if (stack_empty) begin
                            fault_d = FLT_UNF;
                            state_d = S_HALT;
                            pc_d    = pc_q;
                        end else begin
                            stack_pop_enable = 1'b1;
                            gpr_w_enable     = 1'b1;
                            gpr_w_addr       = ra;
                            gpr_w_data       = stack_pop_data;
                        end
                    end
                    OP_JMP: begin
                        pc_d = arg_b[PC_W-1:0];
                    end
                    OP_JZ: begin
                        if (flag_z) pc_d = arg_b[PC_W-1:0];
                    end
                    OP_LDM, OP_STM: begin
                        mem_req  = 1'b1;
                        mem_we   = is_stm;
                        mem_addr = arg_b[MEM_AW-1:0];
                        if (is_stm) begin
                            gpr_r_addr_a = ra;
                            mem_wdata    = gpr_r_data_a;
                        end
                        cnt_d   = '0;
                        state_d = S_MEM_WAIT;
                        pc_d    = pc_q;
                    end
                    OP_HLT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end

            S_MEM_WAIT: begin
                mem_req  = !mem_ack;
                mem_we   = is_stm;
                mem_addr = arg_b[MEM_AW-1:0];
                if (is_stm) begin
                    gpr_r_addr_a = ra;
                    mem_wdata    = gpr_r_data_a;
                end
                if (mem_ack) begin
                    if (!is_stm) begin
                        gpr_w_enable = 1'b1;
                        gpr_w_addr   = ra;
                        gpr_w_data   = mem_rdata;
                    end
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    fault_d = FLT_MEM;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_HALT: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            fault_q <= FLT_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_seq_decoder.sv
// tb_seq_decoder: random and directed programs checked against an
// instruction-level model of the core's architectural state.
module tb_seq_decoder;
    import seq_decoder_pkg::*;

    localparam int DW  = 8;
    localparam int IW  = 8 + 2 * DW;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]    rom_addr;
    logic [IW-1:0] rom_data;
    logic          gpr_w_enable;
    logic [2:0]    gpr_w_addr;
    logic [DW-1:0] gpr_w_data;
    logic [2:0]    gpr_r_addr_a, gpr_r_addr_b;
    logic [DW-1:0] gpr_r_data_a, gpr_r_data_b;
    logic          flags_w_enable, flag_z;
    logic [4:0]    alu_operation;
    logic [DW-1:0] alu_A, alu_B, alu_C;
    logic          stack_push_enable, stack_pop_enable;
    logic [DW-1:0] stack_push_data, stack_pop_data;
    logic          stack_full, stack_empty;
    logic          mem_req, mem_we, mem_ack;
    logic [7:0]    mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          halted;
    logic [1:0]    fault;

    seq_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .gpr_w_enable(gpr_w_enable), .gpr_w_addr(gpr_w_addr),
        .gpr_w_data(gpr_w_data),
        .gpr_r_addr_a(gpr_r_addr_a), .gpr_r_addr_b(gpr_r_addr_b),
        .gpr_r_data_a(gpr_r_data_a), .gpr_r_data_b(gpr_r_data_b),
        .flags_w_enable(flags_w_enable), .flag_z(flag_z),
        .alu_operation(alu_operation), .alu_A(alu_A), .alu_B(alu_B),
        .alu_C(alu_C),
        .stack_push_enable(stack_push_enable),
        .stack_push_data(stack_push_data),
        .stack_pop_enable(stack_pop_enable),
        .stack_pop_data(stack_pop_data),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .halted(halted), .fault(fault)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- environment ----------------
    logic [IW-1:0] rom [256];
    logic [DW-1:0] init_gpr [8];
    logic [DW-1:0] gpr [8];
    logic [DW-1:0] init_ram [256];
    logic [DW-1:0] ram [256];
    logic          init_z;
    logic          zf;
    logic [DW-1:0] stk [4];
    logic [2:0]    sp;
    int            lat [64];
    int            gw_cnt, push_cnt, pop_cnt, req_cyc, acc_idx, reqcnt;
    logic          run_on = 1'b0;

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(posedge clk) begin
        if (!rst_n) begin
            gpr    <= init_gpr;
            gw_cnt <= 0;
        end else if (gpr_w_enable) begin
            gpr[gpr_w_addr] <= gpr_w_data;
            gw_cnt          <= gw_cnt + 1;
        end
    end
    assign gpr_r_data_a = gpr[gpr_r_addr_a];
    assign gpr_r_data_b = gpr[gpr_r_addr_b];

    assign alu_C = (alu_operation == ALU_ADD) ? alu_A + alu_B :
                   (alu_operation == ALU_SUB) ? alu_A - alu_B : '0;

    always @(posedge clk) begin
        if (!rst_n) zf <= init_z;
        else if (flags_w_enable) zf <= (alu_C == '0);
    end
    assign flag_z = zf;

    always @(posedge clk) begin
        if (!rst_n) begin
            sp       <= '0;
            push_cnt <= 0;
            pop_cnt  <= 0;
        end else begin
            if (stack_push_enable) begin
                push_cnt <= push_cnt + 1;
                if (sp < 3'd4) begin
                    stk[sp[1:0]] <= stack_push_data;
                    sp           <= sp + 3'd1;
                end
            end
            if (stack_pop_enable) begin
                pop_cnt <= pop_cnt + 1;
                if (sp > 3'd0) sp <= sp - 3'd1;
            end
        end
    end
    assign stack_full     = (sp == 3'd4);
    assign stack_empty    = (sp == 3'd0);
    assign stack_pop_data = (sp != 3'd0) ? stk[sp[1:0] - 2'd1] : '0;

    // RAM: ack arrives lat[k]+1 cycles after the request's EXEC cycle
    always @(posedge clk) begin
        if (!rst_n) begin
            ram       <= init_ram;
            mem_ack   <= 1'b0;
            mem_rdata <= '0;
            reqcnt    <= 0;
            acc_idx   <= 0;
            req_cyc   <= 0;
        end else begin
            mem_rdata <= DW'($urandom);
            if (mem_req) req_cyc <= req_cyc + 1;
            if (mem_ack) begin
                mem_ack <= 1'b0;
                reqcnt  <= 0;
                acc_idx <= acc_idx + 1;
                if (mem_we) ram[mem_addr] <= mem_wdata;
            end else if (mem_req) begin
                reqcnt <= reqcnt + 1;
                if (reqcnt == lat[acc_idx]) begin
                    mem_ack   <= 1'b1;
                    mem_rdata <= ram[mem_addr];
                end
            end else begin
                reqcnt <= 0;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] mreg [8];
    logic [DW-1:0] mram [256];
    logic [DW-1:0] mstk [4];
    int            e_cyc, e_gw, e_push, e_pop, e_req;
    logic [7:0]    e_pc;
    logic [1:0]    e_fault;
    logic          e_we [64];
    logic [7:0]    e_addr [64];
    logic [DW-1:0] e_wd [64];

    always @(negedge clk) begin
        if (run_on && rst_n && mem_ack) begin
            chk("ack_req", mem_req, 0);
            chk("ack_we", mem_we, e_we[acc_idx]);
            chk("ack_addr", mem_addr, e_addr[acc_idx]);
            if (e_we[acc_idx]) chk("ack_wdata", mem_wdata, e_wd[acc_idx]);
        end
    end

    task automatic model_run();
        logic [7:0]    pc, nxt, op, a, b;
        logic [DW-1:0] r;
        logic [2:0]    ra, rb;
        logic          z;
        int            msp, acc, l;
        bit            done;
        pc = 0; z = init_z; msp = 0; acc = 0; done = 0;
        e_cyc = 0; e_gw = 0; e_push = 0; e_pop = 0; e_req = 0;
        e_fault = 2'd0;
        mreg = init_gpr;
        mram = init_ram;
        for (int s = 0; s < 600 && !done; s++) begin
            {op, a, b} = rom[pc];
            ra = a[2:0];
            rb = b[2:0];
            nxt = pc + 8'd1;
            e_cyc += 2;
            case (op)
                OP_LD:  begin mreg[ra] = mreg[rb]; e_gw++; end
                OP_LDR: begin mreg[ra] = b; e_gw++; end
                OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                    case (op)
                        OP_ADD:  r = mreg[ra] + mreg[rb];
                        OP_SUB:  r = mreg[ra] - mreg[rb];
                        OP_INC:  r = mreg[ra] + 8'd1;
                        default: r = mreg[ra] - 8'd1;
                    endcase
                    mreg[ra] = r;
                    z = (r == 0);
                    e_gw++;
                end
                OP_CLR: begin mreg[ra] = 8'h00; e_gw++; end
                OP_FIL: begin mreg[ra] = 8'hFF; e_gw++; end
                OP_PSH: begin
                    if (msp == 4) begin e_fault = 2'd1; done = 1; end
                    else begin mstk[msp] = mreg[ra]; msp++; e_push++; end
                end
                OP_POP: begin
                    if (msp == 0) begin e_fault = 2'd2; done = 1; end
                    else begin msp--; mreg[ra] = mstk[msp]; e_pop++; e_gw++; end
                end
                OP_JMP: nxt = b;
                OP_JZ:  if (z) nxt = b;
                OP_LDM, OP_STM: begin
                    e_we[acc]   = (op == OP_STM);
                    e_addr[acc] = b;
                    e_wd[acc]   = mreg[ra];
                    l = lat[acc];
                    acc++;
                    if (l >= TMO) begin
                        e_cyc += TMO; e_req += 1 + TMO;
                        e_fault = 2'd3; done = 1;
                    end else begin
                        e_cyc += l + 1; e_req += l + 1;
                        if (op == OP_STM) mram[b] = mreg[ra];
                        else begin mreg[ra] = mram[b]; e_gw++; end
                    end
                end
                OP_HLT: done = 1;
                default: ;
            endcase
            if (!done) pc = nxt;
        end
        e_pc = pc;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_env();
        for (int i = 0; i < 256; i++) begin
            rom[i]      = {OP_HLT, 16'h0000};
            init_ram[i] = DW'($urandom);
        end
        for (int i = 0; i < 8; i++) init_gpr[i] = DW'($urandom);
        for (int i = 0; i < 64; i++) lat[i] = $urandom_range(0, 5);
        init_z = 1'b0;
    endtask

    task automatic run_prog(input string nm);
        int c, d;
        model_run();
        run_on = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({nm, "/rst_strb"}, {gpr_w_enable, flags_w_enable,
            stack_push_enable, stack_pop_enable, mem_req}, 0);
        chk({nm, "/rst_data"}, {gpr_w_addr, gpr_w_data, gpr_r_addr_a,
            gpr_r_addr_b, alu_operation, alu_A, alu_B, stack_push_data,
            mem_we, mem_addr, mem_wdata}, 0);
        chk({nm, "/rst_st"}, {rom_addr, halted, fault}, 0);
        run_on = 1'b1;
        rst_n  = 1'b1;
        c = 0;
        while (!halted && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "/halted"}, halted, 1);
        chk({nm, "/cycles"}, c, e_cyc);
        repeat (3) begin
            @(negedge clk);
            chk({nm, "/idle"}, {gpr_w_enable, flags_w_enable,
                stack_push_enable, stack_pop_enable, mem_req}, 0);
        end
        chk({nm, "/fault"}, fault, e_fault);
        chk({nm, "/pc"}, rom_addr, e_pc);
        for (int i = 0; i < 8; i++) chk({nm, "/gpr"}, gpr[i], mreg[i]);
        d = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== mram[i]) d++;
        chk({nm, "/ram"}, d, 0);
        chk({nm, "/gwr"}, gw_cnt, e_gw);
        chk({nm, "/push"}, push_cnt, e_push);
        chk({nm, "/pop"}, pop_cnt, e_pop);
        chk({nm, "/reqcyc"}, req_cyc, e_req);
        run_on = 1'b0;
    endtask

    task automatic gen_random();
        int n;
        logic [7:0] op, a, b;
        clear_env();
        n = $urandom_range(4, 20);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 11) == 0) op = 8'($urandom_range(16, 255));
            else op = 8'($urandom_range(0, 14));
            a = 8'($urandom);
            b = 8'($urandom);
            if (op == OP_JMP || op == OP_JZ) b = 8'($urandom_range(i + 1, n));
            rom[i] = {op, a, b};
        end
        for (int i = 0; i < 64; i++)
            if ($urandom_range(0, 9) == 0) lat[i] = 255;
        init_z = 1'($urandom);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int c;

        clear_env();
        rom[0] = {OP_LDR, 8'd1, 8'h05};
        rom[1] = {OP_INC, 8'd1, 8'h00};
        rom[2] = {OP_HLT, 8'd0, 8'h00};
        run_prog("ldr_inc_hlt");

        clear_env();
        rom[0]    = {OP_LDR, 8'd0, 8'h01};
        rom[1]    = {OP_DEC, 8'd0, 8'h00};
        rom[2]    = {OP_JZ, 8'd0, 8'h10};
        run_prog("jz_taken");

        clear_env();
        init_z = 1'b1;
        rom[0] = {OP_LDR, 8'd0, 8'h02};
        rom[1] = {OP_DEC, 8'd0, 8'h00};
        rom[2] = {OP_JZ, 8'd0, 8'h10};
        run_prog("jz_not");

        clear_env();
        init_ram[8'h40] = 8'h00;
        rom[0] = {OP_LDR, 8'd2, 8'hA5};
        rom[1] = {OP_STM, 8'd2, 8'h40};
        rom[2] = {OP_LDM, 8'd3, 8'h40};
        lat[0] = 3;
        lat[1] = 0;
        run_prog("stm_ldm");

        clear_env();
        rom[0] = {OP_LDR, 8'd4, 8'h33};
        rom[1] = {OP_LDM, 8'd4, 8'h20};
        lat[0] = 255;
        run_prog("mem_tmo");

        clear_env();
        rom[0] = {OP_LDR, 8'd0, 8'h07};
        for (int i = 1; i <= 5; i++) rom[i] = {OP_PSH, 8'd0, 8'h00};
        run_prog("stk_ovf");

        clear_env();
        rom[0] = {OP_POP, 8'd1, 8'h00};
        run_prog("stk_unf");

        clear_env();
        init_z      = 1'b1;
        init_gpr[0] = 8'h05;
        rom[0]      = {OP_JZ, 8'd0, 8'hFE};
        rom[8'hFE]  = {OP_INC, 8'd0, 8'h00};
        rom[8'hFF]  = {OP_NOP, 8'd0, 8'h00};
        run_prog("pc_wrap");

        for (int t = 0; t < 40; t++) begin
            gen_random();
            run_prog($sformatf("rnd%0d", t));
        end

        // reset pulled low while a store waits for its ack
        clear_env();
        rom[0] = {OP_LDR, 8'd1, 8'h5A};
        rom[1] = {OP_STM, 8'd1, 8'h10};
        lat[0] = 255;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        while (c < 100 && !(mem_req && rom_addr == 8'd1 && req_cyc >= 3)) begin
            @(negedge clk);
            c++;
        end
        chk("mw_reach", mem_req, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mw_rst_req", mem_req, 0);
        chk("mw_rst_pc", rom_addr, 0);
        chk("mw_rst_halt", {halted, fault}, 0);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
